// File: rtl/potential_adder_scheduler_if.sv
// rtl/potential_adder_scheduler_if.sv - scheduler bus: control, weight fetch, potential RAM, adder and spike signals
interface potential_adder_scheduler_if #(
    parameter int NEURON_COUNT = 30,
    parameter int IDX_W        = 5
);
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    weight_req;
    logic [IDX_W-1:0]        weight_addr;
    logic                    weight_valid;
    logic [31:0]             weight_data;
    logic [IDX_W-1:0]        pot_rd_addr;
    logic [31:0]             pot_rd_data;
    logic                    pot_wr_en;
    logic [IDX_W-1:0]        pot_wr_addr;
    logic [31:0]             pot_wr_data;
    logic                    set_adder;
    logic                    clear_adder;
    logic [31:0]             adder_weight;
    logic [31:0]             adder_potential;
    logic [31:0]             adder_result;
    logic                    adder_spike;
    logic                    spike_valid;
    logic [IDX_W-1:0]        spike_id;
    logic [NEURON_COUNT-1:0] spike_vector;

    // scheduler side
    modport master (
        input  start, weight_valid, weight_data, pot_rd_data, adder_result, adder_spike,
        output busy, done, weight_req, weight_addr, pot_rd_addr, pot_wr_en, pot_wr_addr,
               pot_wr_data, set_adder, clear_adder, adder_weight, adder_potential,
               spike_valid, spike_id, spike_vector
    );

    // environment side: weight source, potential RAM, adder
    modport slave (
        output start, weight_valid, weight_data, pot_rd_data, adder_result, adder_spike,
        input  busy, done, weight_req, weight_addr, pot_rd_addr, pot_wr_en, pot_wr_addr,
               pot_wr_data, set_adder, clear_adder, adder_weight, adder_potential,
               spike_valid, spike_id, spike_vector
    );
endinterface

// File: rtl/potential_adder_scheduler.sv
// rtl/potential_adder_scheduler.sv - time-shares one potential adder across NEURON_COUNT neurons per timestep
module potential_adder_scheduler #(
    parameter int NEURON_COUNT = 30,
    parameter int IDX_W        = 5
) (
    input logic                    CLK,
    input logic                    RESET,
    potential_adder_scheduler_if.master bus
);
    localparam logic [2:0] CONFIG  = 3'd0;
    localparam logic [2:0] IDLE    = 3'd1;
    localparam logic [2:0] CLEAR   = 3'd2;
    localparam logic [2:0] FETCH   = 3'd3;
    localparam logic [2:0] WAIT    = 3'd4;
    localparam logic [2:0] COMPUTE = 3'd5;
    localparam logic [2:0] WRITE   = 3'd6;
    localparam logic [2:0] DONE    = 3'd7;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURON_COUNT - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    logic [2:0]              r_state;
    logic [2:0]              w_next;
    logic [IDX_W-1:0]        r_index;
    logic                    r_wait_first;
    logic [31:0]             r_pot;

    logic                    r_busy;
    logic                    r_done;
    logic                    r_weight_req;
    logic [IDX_W-1:0]        r_weight_addr;
    logic [IDX_W-1:0]        r_pot_rd_addr;
    logic                    r_pot_wr_en;
    logic [IDX_W-1:0]        r_pot_wr_addr;
    logic [31:0]             r_pot_wr_data;
    logic                    r_set_adder;
    logic                    r_clear_adder;
    logic [31:0]             r_adder_weight;
    logic [31:0]             r_adder_potential;
    logic                    r_spike_valid;
    logic [IDX_W-1:0]        r_spike_id;
    logic [NEURON_COUNT-1:0] r_spike_vector;

    // next-state decode; start is only looked at in IDLE so it is never queued
    always_comb begin
        w_next = r_state;
        case (r_state)
            CONFIG:  w_next = IDLE;
            IDLE:    w_next = bus.start ? CLEAR : IDLE;
            CLEAR:   w_next = FETCH;
            FETCH:   w_next = WAIT;
            WAIT:    w_next = bus.weight_valid ? COMPUTE : WAIT;
            COMPUTE: w_next = WRITE;
            WRITE:   w_next = (r_index == LAST_IDX) ? DONE : FETCH;
            DONE:    w_next = IDLE;
            default: w_next = CONFIG;
        endcase
    end

    // state, datapath and output registers; outputs are loaded on the edge entering the state they belong to
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state           <= CONFIG;
            r_index           <= '0;
            r_wait_first      <= 1'b0;
            r_pot             <= '0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_weight_req      <= 1'b0;
            r_weight_addr     <= '0;
            r_pot_rd_addr     <= '0;
            r_pot_wr_en       <= 1'b0;
            r_pot_wr_addr     <= '0;
            r_pot_wr_data     <= '0;
            r_set_adder       <= 1'b0;
            r_clear_adder     <= 1'b0;
            r_adder_weight    <= '0;
            r_adder_potential <= '0;
            r_spike_valid     <= 1'b0;
            r_spike_id        <= '0;
            r_spike_vector    <= '0;
        end else begin
            r_state       <= w_next;
            r_set_adder   <= (r_state == CONFIG);
            r_clear_adder <= (w_next == CLEAR);
            r_done        <= (w_next == DONE);
            r_busy        <= (w_next != IDLE);
            r_weight_req  <= (w_next == FETCH) || (w_next == WAIT);
            r_pot_wr_en   <= 1'b0;
            r_spike_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_index        <= '0;
                        r_spike_vector <= '0;
                    end
                end
                CLEAR: begin
                    r_pot_rd_addr <= r_index;
                    r_weight_addr <= r_index;
                end
                FETCH: r_wait_first <= 1'b1;
                WAIT: begin
                    // RAM data for the address issued in FETCH is valid only on the first WAIT cycle's edge
                    r_wait_first <= 1'b0;
                    if (r_wait_first) r_pot <= bus.pot_rd_data;
                    if (bus.weight_valid) begin
                        r_adder_weight    <= bus.weight_data;
                        r_adder_potential <= r_wait_first ? bus.pot_rd_data : r_pot;
                    end
                end
                COMPUTE: begin
                    // the adder output is registered straight into the write-back and spike registers
                    r_adder_weight          <= '0;
                    r_adder_potential       <= '0;
                    r_pot_wr_en             <= 1'b1;
                    r_pot_wr_addr           <= r_index;
                    r_pot_wr_data           <= bus.adder_result;
                    r_spike_vector[r_index] <= bus.adder_spike;
                    r_spike_valid           <= bus.adder_spike;
                    if (bus.adder_spike) r_spike_id <= r_index;
                end
                WRITE: begin
                    if (r_index != LAST_IDX) begin
                        r_index       <= r_index + ONE_IDX;
                        r_pot_rd_addr <= r_index + ONE_IDX;
                        r_weight_addr <= r_index + ONE_IDX;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.weight_req      = r_weight_req;
    assign bus.weight_addr     = r_weight_addr;
    assign bus.pot_rd_addr     = r_pot_rd_addr;
    assign bus.pot_wr_en       = r_pot_wr_en;
    assign bus.pot_wr_addr     = r_pot_wr_addr;
    assign bus.pot_wr_data     = r_pot_wr_data;
    assign bus.set_adder       = r_set_adder;
    assign bus.clear_adder     = r_clear_adder;
    assign bus.adder_weight    = r_adder_weight;
    assign bus.adder_potential = r_adder_potential;
    assign bus.spike_valid     = r_spike_valid;
    assign bus.spike_id        = r_spike_id;
    assign bus.spike_vector    = r_spike_vector;
endmodule

// File: tb/tb_potential_adder_scheduler.sv
// tb/tb_potential_adder_scheduler.sv - self-checking bench for potential_adder_scheduler
module tb_potential_adder_scheduler;
    localparam int N = 30;
    localparam int W = 5;
    localparam logic [31:0] THR = 32'h42200000;
    localparam logic [31:0] TEN = 32'h41200000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    potential_adder_scheduler_if #(.NEURON_COUNT(N), .IDX_W(W)) bus ();
    potential_adder_scheduler #(.NEURON_COUNT(N), .IDX_W(W)) dut (
        .CLK(clk), .RESET(rst), .bus(bus)
    );

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic [31:0] mem [32];
    logic [31:0] wts [32];
    int dly [32];
    int req_cnt [32];
    int log_cnt [32];
    logic [31:0] log_data [32];
    int wcnt = 0;
    int n_done = 0, n_clear = 0, n_spike = 0, last_spike = -1, last_done = 0;
    int exp_wr_addr [$];
    logic [31:0] exp_wr_data [$];
    int exp_sp [$];
    int exp_done_q [$];
    int clr_cyc [$];
    int done_cyc [$];
    logic [N-1:0] exp_sv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic real f2r(input logic [31:0] b);
        logic [10:0] e;
        if (b[30:0] == 31'd0) return 0.0;
        e = {3'b000, b[30:23]} + 11'd896;
        return $bitstoreal({b[31], e, b[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // leaky-integrate-and-fire adder: sum, fire at threshold, subtract threshold on fire
    function automatic logic lif_spk(input logic [31:0] p, input logic [31:0] w);
        return (f2r(p) + f2r(w)) >= f2r(THR);
    endfunction

    function automatic logic [31:0] lif_res(input logic [31:0] p, input logic [31:0] w);
        real s;
        s = f2r(p) + f2r(w);
        return (s >= f2r(THR)) ? r2f(s - f2r(THR)) : r2f(s);
    endfunction

    assign bus.adder_spike  = lif_spk(bus.adder_potential, bus.adder_weight);
    assign bus.adder_result = lif_res(bus.adder_potential, bus.adder_weight);

    always @(posedge clk) cyc++;

    // potential RAM with one-cycle read latency
    always @(posedge clk) bus.pot_rd_data <= mem[bus.pot_rd_addr];

    // weight source: valid after dly[] extra WAIT cycles, a stray valid in FETCH for delayed neurons,
    // and the RAM word changed mid-wait so a late potential capture shows up
    always @(negedge clk) begin
        if (bus.weight_req) begin
            wcnt++;
            req_cnt[bus.weight_addr]++;
        end else begin
            wcnt = 0;
        end
        bus.weight_valid = bus.weight_req &&
            ((wcnt >= 2 + dly[bus.weight_addr]) || (wcnt == 1 && dly[bus.weight_addr] > 0));
        bus.weight_data = (bus.weight_req && wcnt >= 2 + dly[bus.weight_addr]) ? wts[bus.weight_addr] : 32'hDEADBEEF;
        if (bus.weight_req && dly[bus.weight_addr] > 0 && wcnt == 3) mem[bus.weight_addr] = 32'h3F800000;
    end

    // compare process: every strobe is matched against the model's expectations
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.set_adder || bus.clear_adder) check("set_clear_exclusive", bus.set_adder & bus.clear_adder, 0);
            if (bus.weight_req) check("weight_req_while_busy", bus.busy, 1);
            if (bus.clear_adder) begin
                n_clear++;
                clr_cyc.push_back(cyc);
            end
            if (bus.pot_wr_en) begin
                log_cnt[bus.pot_wr_addr]++;
                log_data[bus.pot_wr_addr] = bus.pot_wr_data;
                if (exp_wr_addr.size() == 0) check("unexpected_write", 1, 0);
                else begin
                    check("wr_addr", bus.pot_wr_addr, exp_wr_addr.pop_front());
                    check("wr_data", bus.pot_wr_data, exp_wr_data.pop_front());
                end
            end
            if (bus.spike_valid) begin
                n_spike++;
                last_spike = int'(bus.spike_id);
                if (exp_sp.size() == 0) check("unexpected_spike", 1, 0);
                else check("spike_id", bus.spike_id, exp_sp.pop_front());
            end
            if (bus.done) begin
                n_done++;
                last_done = cyc;
                done_cyc.push_back(cyc);
                if (exp_done_q.size() == 0) check("unexpected_done", 1, 0);
                else check("done_cycle", cyc, exp_done_q.pop_front());
            end
        end
    end

    task automatic push_model(input int upto);
        exp_sv = '0;
        for (int i = 0; i < upto; i++) begin
            exp_wr_addr.push_back(i);
            exp_wr_data.push_back(lif_res(mem[i], wts[i]));
            if (lif_spk(mem[i], wts[i])) begin
                exp_sp.push_back(i);
                exp_sv[i] = 1'b1;
            end
        end
    endtask

    task automatic check_config_pulse(input string tag);
        check({tag, "_cfg_c0_set"}, bus.set_adder, 0);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check({tag, "_cfg_set"}, bus.set_adder, (k == 1));
            if (k >= 2) check({tag, "_cfg_busy"}, bus.busy, 0);
            check({tag, "_cfg_strobes"}, {bus.clear_adder, bus.done, bus.pot_wr_en, bus.weight_req, bus.spike_valid}, 0);
        end
    endtask

    task automatic run_ts(input string tag, input int steps, input bit poke, output int lat);
        int t0, extra, nd0, nc0, budget;
        extra = 0;
        for (int i = 0; i < N; i++) extra += dly[i];
        for (int s = 0; s < steps; s++) push_model(N);
        for (int i = 0; i < 32; i++) begin
            log_cnt[i] = 0;
            req_cnt[i] = 0;
        end
        nd0 = n_done;
        nc0 = n_clear;
        @(negedge clk);
        bus.start = 1'b1;
        t0 = cyc;
        for (int s = 0; s < steps; s++) exp_done_q.push_back(t0 + s * (4*N + 3 + extra) + 4*N + 2 + extra);
        budget = 0;
        while (n_done < nd0 + steps && budget < steps * 600) begin
            @(negedge clk);
            budget++;
            bus.start = (steps > 1) ? (n_done < nd0 + steps) : (poke && cyc == t0 + 50);
        end
        bus.start = 1'b0;
        if (n_done < nd0 + steps) check({tag, "_done_timeout"}, 0, 1);
        lat = last_done - t0;
        repeat (6) @(negedge clk);
        check({tag, "_writes_left"}, exp_wr_addr.size(), 0);
        check({tag, "_spikes_left"}, exp_sp.size(), 0);
        check({tag, "_clear_count"}, n_clear - nc0, steps);
        check({tag, "_spike_vector"}, bus.spike_vector, exp_sv);
        exp_done_q.delete();
        exp_wr_addr.delete();
        exp_wr_data.delete();
        exp_sp.delete();
    endtask

    initial begin
        int lat, bad, budget, nd0;
        bus.start = 1'b0;
        bus.weight_valid = 1'b0;
        bus.weight_data = '0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            wts[i] = TEN;
            dly[i] = 0;
            log_cnt[i] = 0;
            req_cnt[i] = 0;
        end

        // model pinned against hand-computed values
        check("model_10plus0", lif_res(32'h0, TEN), 32'h41200000);
        check("model_50plus5", lif_res(32'h42480000, 32'h40A00000), 32'h41700000);
        check("model_spike", lif_spk(32'h42480000, 32'h40A00000), 1);

        // reset holds every output low, then one set_adder pulse
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.busy, bus.done, bus.weight_req, bus.pot_wr_en, bus.set_adder,
                                bus.clear_adder, bus.spike_valid, bus.spike_vector}, 0);
        check_config_pulse("por");
        mon_en = 1'b1;

        // all-zero potentials, weight 10.0, plus a stray start mid-timestep
        run_ts("A", 1, 1'b1, lat);
        check("A_latency", lat, 122);
        check("A_wr0_data", log_data[0], 32'h41200000);
        bad = 0;
        for (int i = 0; i < N; i++) if (log_cnt[i] != 1) bad++;
        check("A_one_write_each", bad, 0);
        check("A_busy_idle", bus.busy, 0);

        // neuron 7 crosses threshold
        mem[7] = 32'h42480000;
        wts[7] = 32'h40A00000;
        run_ts("B", 1, 1'b0, lat);
        check("B_wr7_data", log_data[7], 32'h41700000);
        check("B_spike_id", last_spike, 7);
        check("B_spike_vec", bus.spike_vector, 30'h80);
        repeat (4) @(negedge clk);
        check("B_spike_vec_hold", bus.spike_vector, 30'h80);

        // neuron 3 waits five extra cycles for its weight
        mem[7] = '0;
        wts[7] = TEN;
        mem[3] = 32'h40000000;
        dly[3] = 5;
        run_ts("C", 1, 1'b0, lat);
        check("C_latency", lat, 127);
        check("C_wr3_data", log_data[3], 32'h41400000);
        check("C_req_cycles_n3", req_cnt[3], 7);
        check("C_req_cycles_n0", req_cnt[0], 2);
        mem[3] = '0;
        dly[3] = 0;

        // reset while neuron 12 is in the cycle before its write
        push_model(12);
        for (int i = 0; i < 32; i++) log_cnt[i] = 0;
        nd0 = n_done;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        budget = 0;
        while (!(bus.pot_wr_en && bus.pot_wr_addr == 5'd11) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("D_reached_n11", budget < 200, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_config_pulse("D");
        check("D_spike_vec_zero", bus.spike_vector, 0);
        repeat (40) @(negedge clk);
        check("D_no_write_12", log_cnt[12], 0);
        check("D_writes_left", exp_wr_addr.size(), 0);
        check("D_no_done", n_done - nd0, 0);
        exp_wr_addr.delete();
        exp_wr_data.delete();
        exp_sp.delete();

        // start held high across a whole timestep and its DONE
        done_cyc.delete();
        clr_cyc.delete();
        run_ts("E", 2, 1'b0, lat);
        if (done_cyc.size() >= 1 && clr_cyc.size() >= 2) check("E_restart_gap", clr_cyc[1] - done_cyc[0], 2);
        else check("E_two_timesteps", {done_cyc.size(), clr_cyc.size()}, {32'd2, 32'd2});

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/potential_adder_scheduler.md
POTENTIAL_ADDER_SCHEDULER -- requirements
Module: potential_adder_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NEURON_COUNT, 30, neurons time-shared on one potential adder
  IDX_W, 5, neuron index width; 2^IDX_W >= NEURON_COUNT
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  CLK  in  1  single clock; all state updates on rising edge
  RESET  in  1  synchronous, active-high reset
  start  in  1  request one timestep
  busy  out  1  high in every state except IDLE
  done  out  1  one-cycle pulse at timestep end
  weight_req  out  1  weight fetch request
  weight_addr  out  IDX_W  neuron index of request
  weight_valid  in  1  weight_data valid
  weight_data  in  32  IEEE-754 input weight
  pot_rd_addr  out  IDX_W  potential RAM read address; 1-cycle read latency
  pot_rd_data  in  32  decayed potential
  pot_wr_en  out  1  potential RAM write strobe
  pot_wr_addr  out  IDX_W  write address
  pot_wr_data  out  32  updated potential
  set_adder  out  1  adder configuration pulse
  clear_adder  out  1  adder clear pulse
  adder_weight  out  32  adder weight operand
  adder_potential  out  32  adder potential operand
  adder_result  in  32  combinational final potential
  adder_spike  in  1  combinational spike flag
  spike_valid  out  1  one-cycle pulse per spiking neuron
  spike_id  out  IDX_W  index of spiking neuron
  spike_vector  out  NEURON_COUNT  spikes of current/last timestep

Function
REQ-003 FSM states SHALL be CONFIG, IDLE, CLEAR, FETCH, WAIT, COMPUTE, WRITE, DONE; all outputs registered.
REQ-004 CONFIG SHALL assert set_adder for exactly one cycle, then go to IDLE unconditionally.
REQ-005 IDLE with start=1 SHALL go to CLEAR; start in any other state SHALL be ignored (not queued).
REQ-006 CLEAR SHALL assert clear_adder one cycle, zero index and spike_vector, then go to FETCH.
REQ-007 FETCH SHALL drive pot_rd_addr=weight_addr=index, raise weight_req, go to WAIT.
REQ-008 WAIT SHALL capture pot_rd_data on its first cycle, hold weight_req high until weight_valid=1, capture weight_data that cycle, then go to COMPUTE; no timeout; weight_valid=1 on first WAIT cycle SHALL be accepted.
REQ-009 weight_valid outside WAIT SHALL be ignored; weight_req SHALL be low outside FETCH/WAIT.
REQ-010 COMPUTE SHALL drive adder_weight/adder_potential from captured values for one cycle and register adder_result and adder_spike at its end.
REQ-011 WRITE SHALL pulse pot_wr_en with pot_wr_addr=index, pot_wr_data=registered result; set spike_vector[index]=registered spike; if spike=1, pulse spike_valid with spike_id=index.
REQ-012 From WRITE: index==NEURON_COUNT-1 -> DONE; else index+1 -> FETCH; index SHALL never exceed NEURON_COUNT-1.
REQ-013 DONE SHALL pulse done one cycle and go to IDLE; start during DONE SHALL be ignored.
REQ-014 With zero-wait weights, timestep latency SHALL be 4*NEURON_COUNT+2 cycles from start sample to done pulse (122 for default).
REQ-015 Exactly one pot_wr_en pulse per neuron per timestep, in ascending index order.
REQ-016 spike_vector SHALL hold after DONE until next CLEAR.
REQ-017 set_adder and clear_adder SHALL never be high together.

Reset
REQ-018 RESET=1 SHALL override all inputs, enter CONFIG next cycle, and zero every output, index, and captured register.
REQ-019 RESET mid-timestep SHALL abort with no further pot_wr_en, spike_valid, or done, and SHALL repeat the CONFIG set_adder pulse.

Verification
REQ-020 Reset release -> set_adder high exactly cycle 1, busy low from cycle 2, no other strobes.
REQ-021 start, weights always valid, pot=0, weight=32'h41200000, adder model LIF threshold 32'h42200000 -> 30 writes of 32'h41200000, no spikes, done 122 cycles after start.
REQ-022 Neuron 7 pot=32'h42480000, weight=32'h40A00000 -> spike_valid with spike_id=7, spike_vector[7]=1, write 32'h41700000 to addr 7.
REQ-023 weight_valid delayed 5 cycles for neuron 3 -> weight_req held, potential captured on first WAIT cycle, done delayed exactly 5 cycles.
REQ-024 RESET asserted during neuron 12 WRITE-1 -> no write to addr 12, no done, CONFIG pulse, spike_vector zero.
REQ-025 start held high through timestep and DONE -> exactly one timestep, second starts only after IDLE re-sampled start.
